// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] nxt_q, nxt_r, q_res, r_res, a_op, b_op;

  // The partial remainder is always < divisor after an iteration, so only the
  // shifted/trial values need the extra (WIDTH+1)th bit; the register holds WIDTH.
  assign shifted = {rem_q, qreg_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign nxt_q   = {qreg_q[WIDTH-2:0], ~trial[WIDTH]};
  assign nxt_r   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sgnq_q, sgnq_d, sgnr_q, sgnr_d;

  assign a_op  = a[WIDTH-1] ? ('0 - a) : a;
  assign b_op  = b[WIDTH-1] ? ('0 - b) : b;
  assign q_res = sgnq_q ? ('0 - nxt_q) : nxt_q;
  assign r_res = sgnr_q ? ('0 - nxt_r) : nxt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgnq_q <= 1'b0;
      sgnr_q <= 1'b0;
    end else begin
      sgnq_q <= sgnq_d;
      sgnr_q <= sgnr_d;
    end
  end
`else
  assign a_op  = a;
  assign b_op  = b;
  assign q_res = nxt_q;
  assign r_res = nxt_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvsr_q  <= '0;
      qreg_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvsr_q  <= dvsr_d;
      qreg_q  <= qreg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvsr_d  = dvsr_q;
    qreg_d  = qreg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (b == '0) begin
            quo_d   = '1;
            rmd_d   = a;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dvsr_d  = b_op;
            qreg_d  = a_op;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sgnq_d  = a[WIDTH-1] ^ b[WIDTH-1];
            sgnr_d  = a[WIDTH-1];
`endif
          end
        end
      end
      S_RUN: begin
        qreg_d = nxt_q;
        rem_d  = nxt_r;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_res;
          rmd_d   = r_res;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign q           = quo_q;
  assign r           = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// negedge monitor pops and checks them (values and latency) on every done.
module tb_seq_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, div_by_zero;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_q"},   32'(q), 32'(mon_e.q));
        chk({mon_e.name, "_r"},   32'(r), 32'(mon_e.r));
        chk({mon_e.name, "_dbz"}, 32'(div_by_zero), 32'(mon_e.dbz));
        chk({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Called at a negedge; start is held across exactly one rising edge.
  task automatic issue(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    exp_t e;
    e.q = eq; e.r = er; e.dbz = edbz; e.name = nm;
    e.due = cyc + ((bv == '0) ? 1 : W + 1);
    a = av; b = bv; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while (sb.size() != 0 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int maxc);
    int k = 0;
    while (done !== 1'b1 && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int nbusy;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(q),    32'd0);
    chk("rst_r",    32'(r),    32'd0);
    chk("rst_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: busy for 16 cycles, result held afterwards
    issue("div_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    nbusy = 0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nbusy), 32'd16);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_q", 32'(q), 32'd14);
      chk("hold_r", 32'(r), 32'd2);
    end

    issue("div_ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    drain(40);
    issue("div_3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
    drain(40);
    issue("div_0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0);
    drain(40);

    issue("div_5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    chk("dbz_busy", 32'(busy), 32'd0);
    chk("dbz_done", 32'(done), 32'd1);
    drain(10);

    // start during RUN is ignored
    issue("prot_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    repeat (3) @(negedge clk);
    a = 16'd9; b = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("prot_busy", 32'(busy), 32'd1);
    wait_done(40);
    // back-to-back start while done is high
    issue("prot_b2b_9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    drain(40);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue("mneg_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
    drain(40);
    issue("m7_2",    16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0);
    drain(40);
    issue("7_m2",    16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0);
    drain(40);
`else
    issue("u8000_ffff", 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
    drain(40);
    issue("ufff9_2",    16'hFFF9, 16'd2,    16'h7FFC, 16'd1,    1'b0);
    drain(40);
    issue("u7_fffe",    16'd7,    16'hFFFE, 16'h0000, 16'd7,    1'b0);
    drain(40);
`endif

    // Reset mid-operation aborts with no done
    issue("abort_1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_q",    32'(q),    32'd0);
    chk("mid_rst_r",    32'(r),    32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue("div_1000_3", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider (restoring shift-subtract), one quotient bit per clock.
- Inverse of the datapath's partial-product multiplier. Sits beside it in the lab ALU, so MUL and DIV share operand buses.
- Accepts dividend/divisor on a start pulse and returns quotient and remainder with a done pulse.

Parameters:
- WIDTH, 16, operand/quotient/remainder width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- a  input  WIDTH  dividend; sampled on the accepting edge only.
- b  input  WIDTH  divisor; sampled on the accepting edge only.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse: q/r/div_by_zero valid.
- q  output  WIDTH  quotient; held until next accepted start.
- r  output  WIDTH  remainder; held until next accepted start.
- div_by_zero  output  1  set with done when b==0; held with q/r.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, iteration counter=0, internal regs=0. Reset during RUN aborts the operation; no done is produced.
- States:
  - IDLE: busy=0, done=0. On start, go to RUN.
  - RUN: busy=1. Perform one iteration per edge.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accepting edge, b≠0: latch divisor=b, quotient shift reg=a, partial remainder (WIDTH+1 bits)=0, counter=0. Clear div_by_zero. Go to RUN.
- Accepting edge, b==0: skip RUN. Load q=all ones, r=a, div_by_zero=1. Go to DONE. done is high after 1 edge.
- RUN iteration:
  - Shift {rem, qreg} left 1.
  - trial = rem − {0,divisor}.
  - If trial ≥ 0: rem=trial, qreg[0]=1. Else keep rem, qreg[0]=0.
  - counter++.
- On the edge completing iteration WIDTH (counter == WIDTH−1): load q=qreg result, r=rem[WIDTH−1:0], go to DONE.
- Latency: done is high after exactly WIDTH+1 rising edges from the accepting edge (17 for WIDTH=16).
- start while in RUN is ignored. a/b changes during RUN have no effect.
- start while in DONE is accepted on that edge (back-to-back). done falls and the new operation begins.
- q/r change only when loaded at completion or on reset. They hold across IDLE and during a new RUN.
- Result invariant (b≠0): a == q*b + r, with r < b. No overflow is possible for unsigned operands.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - a and b are treated as two's complement.
  - On accept, latch operand magnitudes, sign_q = a[MSB]^b[MSB], sign_r = a[MSB].
  - At completion, negate q if sign_q and negate r if sign_r (truncating division; remainder takes the dividend's sign).
  - Negation is applied on the completion edge, so latency is unchanged.
  - Special case: most-negative / −1 returns q = most-negative, r = 0, div_by_zero = 0.
  - Divide by zero returns q = all ones, r = a.
- Undefined: purely unsigned behaviour as above; no sign logic synthesized.

Test Plan:
- Basic divide, WIDTH=16: a=100, b=7, start 1 cycle -> busy high for 16 cycles; done after 17 edges; q=14, r=2, div_by_zero=0. q/r hold 10 cycles after.
- Edge values: a=0xFFFF, b=1 -> q=0xFFFF, r=0. Then a=3, b=10 -> q=0, r=3. Then a=0, b=5 -> q=0, r=0.
- Divide by zero: a=5, b=0 -> done after 1 edge, q=0xFFFF, r=5, div_by_zero=1, busy never high.
- Protocol:
  - Step 1: start with a=100, b=7. At cycle 5, pulse start with a=9, b=3 -> result q=14, r=2 at 17 edges.
  - Step 2: while done is high, start with a=9, b=3 -> accepted; next done 17 edges later with q=3, r=0.
- Reset mid-op: start a=1000, b=3. Assert rst at cycle 8 -> busy, done, q, r drop to 0 immediately; no done pulse follows. Then a=1000, b=3 -> q=333, r=1.
- SEQ_DIVIDER_SIGNED_EN:
  - a=0xFFF9 (−7), b=2 -> q=0xFFFD (−3), r=0xFFFF (−1).
  - a=7, b=0xFFFE (−2) -> q=0xFFFD, r=1.
  - a=0x8000, b=0xFFFF -> q=0x8000, r=0.
